// File: rtl/seg7_scan_mux_if.sv
// Bus between the digit sources and the 7-segment scanner: control and packed
// digit inputs toward the scanner, registered segment/anode drive back out.
interface seg7_scan_mux_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DW     = 4,
    parameter int unsigned SW_W   = $clog2(DIGITS)
);

    logic                   mode;      // 0 = auto scan, 1 = manual select
    logic [SW_W-1:0]        sw;        // manual digit index
    logic                   blank_lz;  // 1 = blank leading zero digits
    logic [DIGITS*DW-1:0]   data;      // digit i at data[i*DW +: DW]
    logic [DW-1:0]          cnt;       // value of the selected digit
    logic [DIGITS-1:0]      an;        // active-low one-hot anode enables
    logic [SW_W-1:0]        sel;       // current digit index
    logic                   tick;      // one-cycle refresh strobe

    // Digit source / display side.
    modport master (
        output mode,
        output sw,
        output blank_lz,
        output data,
        input  cnt,
        input  an,
        input  sel,
        input  tick
    );

    // Scanner side.
    modport slave (
        input  mode,
        input  sw,
        input  blank_lz,
        input  data,
        output cnt,
        output an,
        output sel,
        output tick
    );

endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment digit scanner. One digit at a time is routed to
// the shared segment decoder; the digit index advances on a prescaled refresh
// tick (auto) or follows sw (manual). Each digit change passes through a
// dead-time window with every anode off to avoid ghosting, and leading zero
// digits can optionally be blanked. All outputs are registered.
module seg7_scan_mux #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DW     = 4,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned DEAD   = 2,
    parameter int unsigned SW_W   = $clog2(DIGITS)
) (
    input  logic            clk,
    input  logic            rst,
    seg7_scan_mux_if.slave  bus
);

    // Prescaler width; DIV >= 4 so this is always at least 2 bits.
    localparam int unsigned PW = $clog2(DIV);

    localparam logic [PW-1:0]   PRE_LAST  = PW'(DIV - 1);
    // DEAD <= DIV-2, so the dead-time count fits in the prescaler width.
    localparam logic [PW-1:0]   DEAD_LOAD = PW'(DEAD);
    localparam logic [SW_W-1:0] IDX_LAST  = SW_W'(DIGITS - 1);

    typedef enum logic [0:0] {
        StShow,
        StDead
    } state_e;

    // Prescaler and refresh strobe
    logic [PW-1:0]      pre_q, pre_d;
    logic               tick_q, tick_d;
    logic               pre_wrap;

    // Scan state
    state_e             state_q, state_d;
    logic [PW-1:0]      dcnt_q, dcnt_d;
    logic [SW_W-1:0]    idx_q, idx_d;
    logic [SW_W-1:0]    tgt_q, tgt_d;
    logic [SW_W-1:0]    idx_next;

    // Output drive
    logic [DW-1:0]      cnt_q, cnt_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [SW_W-1:0]    sel_q, sel_d;

    // Digit lookup for the current index
    logic [DW-1:0]      cur_digit;
    logic               idx_valid;
    logic               upper_zero;
    logic               blank;

    // Prescaler next value; the strobe marks the cycle after the last count.
    always_comb begin
        pre_wrap = (pre_q == PRE_LAST);
        pre_d    = pre_wrap ? '0 : pre_q + 1'b1;
        tick_d   = pre_wrap;
    end

    // Prescaler and strobe registers; free-running in both modes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    // Auto-scan successor index; an out-of-range index left over from manual
    // mode also restarts at digit 0.
    always_comb begin
        idx_next = (idx_q >= IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Scan FSM next state: SHOW holds a digit, DEAD blanks between digits.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        idx_d   = idx_q;
        tgt_d   = tgt_q;

        case (state_q)
            StShow: begin
                // The refresh decision uses the same wrap condition that raises
                // tick, so the anodes go dark the cycle after tick.
                if (bus.mode) begin
                    if (bus.sw != idx_q) begin
                        state_d = StDead;
                        dcnt_d  = DEAD_LOAD;
                        tgt_d   = bus.sw;
                    end
                end else if (pre_wrap) begin
                    state_d = StDead;
                    dcnt_d  = DEAD_LOAD;
                    tgt_d   = idx_next;
                end
            end
            StDead: begin
                // Ticks arriving here are dropped, not queued.
                if (dcnt_q == '0) begin
                    state_d = StShow;
                    // Manual mode re-samples sw so the latest selection wins.
                    idx_d   = bus.mode ? bus.sw : tgt_q;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StShow;
            end
        endcase
    end

    // Scan FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StShow;
            dcnt_q  <= '0;
            idx_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
        end
    end

    // Select the current digit and check whether it is a leading zero.
    always_comb begin
        cur_digit  = '0;
        idx_valid  = 1'b0;
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == SW_W'(i)) begin
                cur_digit = bus.data[i*DW +: DW];
                idx_valid = 1'b1;
            end
            if ((SW_W'(i) > idx_q) && (bus.data[i*DW +: DW] != '0)) begin
                upper_zero = 1'b0;
            end
        end
        // Digit 0 always lights so a zero value still shows something.
        blank = bus.blank_lz && (idx_q != '0) && (cur_digit == '0) && upper_zero;
    end

    // Output next values; unused indices and DEAD leave every anode off.
    always_comb begin
        an_d  = '1;
        cnt_d = idx_valid ? cur_digit : '0;
        sel_d = idx_q;
        if ((state_q == StShow) && idx_valid && !blank) begin
            an_d = ~(DIGITS'(1) << idx_q);
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            an_q  <= '1;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            an_q  <= an_d;
            sel_q <= sel_d;
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.an   = an_q;
    assign bus.sel  = sel_q;
    assign bus.tick = tick_q;

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed 7-segment digit scanner, a parametrised successor to the static 4:1 digit selector. It takes DIGITS packed digit values and drives one digit at a time through a shared segment decoder. Digit selection is either automatic, stepping on a prescaled refresh tick, or manual, following SW. Every digit change inserts a dead-time gap, and leading-zero blanking is optional. The block sits between the counter/BCD stages and the existing segment decoder and anode pins.

## Interface
- DIGITS, 4: number of digits scanned, 2..16.
- DW, 4: width of one digit value.
- DIV, 50000: refresh prescaler period in CLK cycles, ≥ 4.
- DEAD, 2: dead-time cycles with all anodes off at each digit change; 0..DIV-2.
- SW_W, $clog2(DIGITS): width of the manual select.
- CLK  in  1  system clock; everything is sampled on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- MODE  in  1  0 = auto scan, 1 = manual select via SW.
- SW  in  SW_W  manual digit index.
- BLANK_LZ  in  1  1 = blank leading zero digits.
- DATA  in  DIGITS*DW  packed digits; digit i = DATA[i*DW +: DW]; digit 0 is least significant.
- CNT  out  DW  value of the currently selected digit, registered.
- AN  out  DIGITS  active-low one-hot anode enables, registered.
- SEL  out  SW_W  current digit index, registered.
- TICK  out  1  one-cycle refresh strobe, registered.

## Operation
- Prescaler PRE counts 0..DIV-1 and wraps. It free-runs in both modes.
- TICK = 1 for exactly the one cycle after PRE == DIV-1.
- FSM state SHOW:
  - Auto mode: a TICK moves the FSM to DEAD. The target index is IDX+1, wrapping DIGITS-1 → 0.
  - Manual mode: SW != IDX moves the FSM to DEAD with target SW.
  - Both conditions are evaluated in the same cycle; MODE selects which one applies.
- FSM state DEAD:
  - AN = all ones. DCNT counts down from DEAD.
  - At DCNT == 0, IDX is loaded with the target and the FSM returns to SHOW.
  - In manual mode the target is re-sampled from SW on the exit cycle; the last SW value wins.
  - With DEAD = 0, DEAD lasts a single cycle with all anodes off.
- TICK received while in DEAD: ignored, no queued advance.
- MODE change: takes effect the next cycle.
  - Manual → auto: the next TICK advances from the current IDX.
  - Auto → manual: if SW != IDX, a DEAD sequence starts immediately.
- SW ≥ DIGITS (non-power-of-2 DIGITS): treated as an unused index.
  - IDX takes the value, SEL reports it, AN = all ones, CNT = 0.
- Leading-zero blanking applies when BLANK_LZ = 1, IDX != 0, digit IDX == 0, and all digits above IDX == 0.
  - The anode is then forced off (AN = all ones).
  - CNT still carries the value. Digit 0 is never blanked.
- In SHOW with a valid IDX, AN = ~(1 << IDX) and CNT = digit IDX of the current DATA.
- Reset mid-scan: all state is cleared immediately and asynchronously. The scan restarts at digit 0 with PRE = 0.

## Timing
- Reset values: CNT = 0, AN = all ones, SEL = 0, TICK = 0, PRE = 0, IDX = 0, DCNT = 0, FSM = SHOW.
- First anode assertion (AN[0] = 0) occurs on the first CLK edge after RST deasserts.
- All outputs are registered. A DATA or BLANK_LZ change appears on CNT/AN one cycle later.
- Auto scan, steady state, per digit:
  - AN is off for DEAD+1 cycles, starting the cycle after TICK.
  - The new digit is then shown for DIV-DEAD-1 cycles.
  - Full frame = DIGITS*DIV cycles.
- Manual: an SW change seen at edge n produces all anodes off from n+1 through n+DEAD+1. The new anode is asserted at n+DEAD+2.
- SEL and CNT update in the same cycle as the new anode.
- No combinational path from any input to any output.

## Test plan
- Reset, then auto mode: DIGITS=4, DIV=8, DEAD=2, DATA=16'h4321.
  - Expect AN to cycle 1110 → 1101 → 1011 → 0111 with CNT = 1, 2, 3, 4.
  - Each digit is shown for 5 cycles, separated by 3-cycle AN=1111 gaps.
  - TICK pulses every 8 cycles.
- Wrap: from SEL=3 the next TICK yields SEL=0, CNT=1, AN=1110, after the dead gap.
- Manual: MODE=1, SW 0→2 at edge n.
  - Expect AN=1111 from n+1 through n+3; AN=1011, CNT=3 at n+4.
  - SW=2→0→2 toggled within the DEAD window: the final index is 2.
- Blanking: DATA=16'h0050, BLANK_LZ=1.
  - Digits 3 and 2 show AN=1111. Digits 1 and 0 light with CNT=5 and 0.
  - With BLANK_LZ=0, all four digits light.
- Async reset asserted mid-DEAD, between clock edges: outputs go to reset values immediately. After release, the scan restarts at digit 0.
- DIGITS=3 build, manual SW=3: SEL=3, AN=111, CNT=0. TICK continues every DIV cycles.
